// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states, default base.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0100_0000;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response valid-ready channels between the memory stage and the responder.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_rw;
  logic [1:0]  req_size;
  logic        req_unsign;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_rw, req_size, req_unsign, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_rw, req_size, req_unsign, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: store byte enables/replicated data, load extraction and extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  ofs,
  input  logic [1:0]  size,
  input  logic        unsign,
  input  logic [31:0] wdata,
  input  logic [31:0] rdword,
  output logic [3:0]  byte_en,
  output logic [31:0] wword,
  output logic [31:0] rdata_ext,
  output logic        misalign
);
  logic [31:0] shifted;

  always_comb begin
    byte_en   = 4'b0000;
    wword     = 32'd0;
    rdata_ext = 32'd0;
    misalign  = 1'b0;
    shifted   = rdword >> {ofs, 3'b000};
    // Store data is replicated across lanes so the byte enables alone pick the target lane.
    case (size)
      SIZE_BYTE: begin
        byte_en   = 4'b0001 << ofs;
        wword     = {4{wdata[7:0]}};
        rdata_ext = {{24{~unsign & shifted[7]}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        byte_en   = 4'b0011 << ofs;
        wword     = {2{wdata[15:0]}};
        rdata_ext = {{16{~unsign & shifted[15]}}, shifted[15:0]};
        misalign  = ofs[0];
      end
      SIZE_WORD: begin
        byte_en   = 4'b1111;
        wword     = wdata;
        rdata_ext = shifted;
        misalign  = (ofs != 2'd0);
      end
      default: misalign = 1'b1;
    endcase
  end
endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle load/store responder: IDLE/WAIT/RESP FSM, fixed latency, word storage with lane control.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input logic           clock,
  input logic           reset,
  dmem_responder_if.slave bus
);
  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN    = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0] CNT_INIT = 4'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  state_t      state_p0, state_nxt;
  logic [3:0]  cnt_p0, cnt_nxt;
  logic [31:0] addr_p0, wdata_p0;
  logic        rw_p0, unsign_p0;
  logic [1:0]  size_p0;
  logic [31:0] acc_addr, acc_wdata;
  logic        acc_rw, acc_unsign;
  logic [1:0]  acc_size;
  logic [32:0] offset;
  logic        in_range, acc_err, commit, misalign;
  logic [IDX_W-1:0] idx;
  logic [3:0]  byte_en;
  logic [31:0] wword, rdword, rdata_ext;
  logic [31:0] rsp_rdata_p1;
  logic        rsp_err_p1;
  logic [31:0] mem [DEPTH_WORDS];

  always_comb begin
    state_nxt = state_p0;
    cnt_nxt   = cnt_p0;
    case (state_p0)
      IDLE: if (bus.req_valid) begin
        if (LATENCY == 1) state_nxt = RESP;
        else begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_INIT;
        end
      end
      WAIT: if (cnt_p0 == 4'd0) state_nxt = RESP;
            else cnt_nxt = cnt_p0 - 4'd1;
      RESP: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_p0 <= IDLE;
      cnt_p0   <= 4'd0;
    end else begin
      state_p0 <= state_nxt;
      cnt_p0   <= cnt_nxt;
    end
  end

  // Capture stage: with LATENCY==1 the access commits on the acceptance edge, so IDLE uses live inputs.
  always_ff @(posedge clock) begin
    if (state_p0 == IDLE && bus.req_valid) begin
      addr_p0   <= bus.req_addr;
      rw_p0     <= bus.req_rw;
      size_p0   <= bus.req_size;
      unsign_p0 <= bus.req_unsign;
      wdata_p0  <= bus.req_wdata;
    end
  end

  always_comb begin
    acc_addr   = (state_p0 == IDLE) ? bus.req_addr   : addr_p0;
    acc_rw     = (state_p0 == IDLE) ? bus.req_rw     : rw_p0;
    acc_size   = (state_p0 == IDLE) ? bus.req_size   : size_p0;
    acc_unsign = (state_p0 == IDLE) ? bus.req_unsign : unsign_p0;
    acc_wdata  = (state_p0 == IDLE) ? bus.req_wdata  : wdata_p0;
    // 33-bit difference: addresses below the base go negative instead of wrapping into range.
    offset     = {1'b0, acc_addr} - {1'b0, BASE_ADDR};
    in_range   = ~offset[32] && (offset < SPAN);
    idx        = offset[IDX_W+1:2];
    rdword     = mem[idx];
    acc_err    = misalign | ~in_range;
    commit     = (state_nxt == RESP) && (state_p0 != RESP) && !reset;
  end

  dmem_lane_align u_align (
    .ofs       (acc_addr[1:0]),
    .size      (acc_size),
    .unsign    (acc_unsign),
    .wdata     (acc_wdata),
    .rdword    (rdword),
    .byte_en   (byte_en),
    .wword     (wword),
    .rdata_ext (rdata_ext),
    .misalign  (misalign)
  );

  // Commit stage: store lanes and the registered load result land on the edge entering RESP.
  always_ff @(posedge clock) begin
    if (commit && acc_rw && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_rdata_p1 <= 32'd0;
      rsp_err_p1   <= 1'b0;
    end else if (commit) begin
      rsp_rdata_p1 <= (acc_err || acc_rw) ? 32'd0 : rdata_ext;
      rsp_err_p1   <= acc_err;
    end
  end

  assign bus.req_ready = (state_p0 == IDLE);
  assign bus.rsp_valid = (state_p0 == RESP);
  assign bus.rsp_rdata = rsp_rdata_p1;
  assign bus.rsp_err   = rsp_err_p1;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY 2/1/15 instances, directed steps plus randomized ops vs a byte-level model.
module tb_dmem_responder;
  localparam longint unsigned BASE  = 64'h0100_0000;
  localparam longint unsigned DEPTH = 1024;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  logic [7:0] mdl [int unsigned];

  dmem_responder_if if2 ();
  dmem_responder_if if1 ();
  dmem_responder_if if15 ();
  virtual dmem_responder_if v2, v1, v15;

  dmem_responder #(.LATENCY(2))  u2  (.clock(clk), .reset(reset), .bus(if2.slave));
  dmem_responder #(.LATENCY(1))  u1  (.clock(clk), .reset(reset), .bus(if1.slave));
  dmem_responder #(.LATENCY(15)) u15 (.clock(clk), .reset(reset), .bus(if15.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus(input virtual dmem_responder_if vif);
    vif.req_valid = 0; vif.req_addr = 0; vif.req_rw = 0; vif.req_size = 0;
    vif.req_unsign = 0; vif.req_wdata = 0; vif.rsp_ready = 1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Byte-addressed reference: rules applied directly to address arithmetic and a byte map.
  task automatic model(input logic [31:0] addr, input logic rw, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata,
                       output logic [31:0] exp, output logic eerr, output logic known);
    longint unsigned a;
    int nb;
    logic [31:0] val;
    a    = 64'(addr);
    nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    eerr = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0)
           || (a < BASE) || (a >= BASE + 4 * DEPTH);
    exp = 0; known = 1; val = 0;
    if (!eerr) begin
      if (rw) begin
        for (int i = 0; i < nb; i++) mdl[addr + 32'(i)] = wdata[8*i +: 8];
      end else begin
        for (int i = 0; i < nb; i++) begin
          if (mdl.exists(addr + 32'(i))) val[8*i +: 8] = mdl[addr + 32'(i)];
          else known = 0;
        end
        if (nb == 1 && !uns && val[7])  val[31:8]  = 24'hFFFFFF;
        if (nb == 2 && !uns && val[15]) val[31:16] = 16'hFFFF;
        exp = val;
      end
    end
  endtask

  task automatic xact(input virtual dmem_responder_if vif, input logic [31:0] addr, input logic rw,
                      input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output int lat);
    int n = 0;
    while (!vif.req_ready && n < 50) begin tick(); n++; end
    vif.req_valid = 1; vif.req_addr = addr; vif.req_rw = rw; vif.req_size = size;
    vif.req_unsign = uns; vif.req_wdata = wdata; vif.rsp_ready = 1;
    lat = 0;
    do begin
      tick();
      lat++;
      vif.req_valid = 0; vif.req_addr = $urandom(); vif.req_size = 2'($urandom());
      vif.req_wdata = $urandom(); vif.req_rw = 1'($urandom());
    end while (!vif.rsp_valid && lat < 40);
    rdata = vif.rsp_rdata;
    err   = vif.rsp_err;
    tick();
  endtask

  task automatic op2(input string tag, input logic [31:0] addr, input logic rw, input logic [1:0] size,
                     input logic uns, input logic [31:0] wdata, output logic [31:0] rd);
    logic [31:0] exp;
    logic er, eerr, known;
    int lat;
    xact(v2, addr, rw, size, uns, wdata, rd, er, lat);
    model(addr, rw, size, uns, wdata, exp, eerr, known);
    chk({tag, "_lat"}, lat, 2);
    chk({tag, "_err"}, er, eerr);
    if (known) chk({tag, "_data"}, rd, exp);
    chk({tag, "_drop"}, v2.rsp_valid, 0);
  endtask

  task automatic thru(input virtual dmem_responder_if vif, input int lat, input string tag,
                      input logic [31:0] addr);
    int t[$];
    logic prev = 0;
    int n = 0;
    vif.rsp_ready = 1; vif.req_valid = 1; vif.req_addr = addr; vif.req_rw = 0;
    vif.req_size = 2; vif.req_unsign = 0;
    for (int c = 0; c < 200 && t.size() < 3; c++) begin
      tick();
      if (vif.rsp_valid && !prev) t.push_back(c);
      prev = vif.rsp_valid;
    end
    vif.req_valid = 0;
    chk({tag, "_count"}, t.size(), 3);
    if (t.size() >= 3) begin
      chk({tag, "_gap1"}, t[1] - t[0], lat + 1);
      chk({tag, "_gap2"}, t[2] - t[1], lat + 1);
    end
    while (!(vif.req_ready && !vif.rsp_valid) && n < 40) begin tick(); n++; end
  endtask

  initial begin
    logic [31:0] rd, r0;
    logic er, e0;
    int lat;
    v2 = if2; v1 = if1; v15 = if15;
    idle_bus(v2); idle_bus(v1); idle_bus(v15);
    reset = 1;
    tick(); tick();
    chk("rst_req_ready", v2.req_ready, 1);
    chk("rst_rsp_valid", v2.rsp_valid, 0);
    chk("rst_rdata", v2.rsp_rdata, 0);
    chk("rst_err", v2.rsp_err, 0);
    chk("rst_ready_l1", v1.req_ready, 1);
    chk("rst_ready_l15", v15.req_ready, 1);
    reset = 0;
    tick();

    for (int w = 0; w < 16; w++) op2("init", 32'h0100_0000 + 32'(4 * w), 1, 2, 0, $urandom(), rd);

    op2("st_word", 32'h0100_0010, 1, 2, 0, 32'hDEADBEEF, rd);
    chk("st_word_rdata0", rd, 0);
    op2("ld_word", 32'h0100_0010, 0, 2, 0, 0, rd);
    chk("ld_word_val", rd, 32'hDEADBEEF);
    op2("st_byte", 32'h0100_0011, 1, 0, 0, 32'h0000_007F, rd);
    op2("ld_word2", 32'h0100_0010, 0, 2, 0, 0, rd);
    chk("ld_word2_val", rd, 32'hDEAD7FEF);
    op2("ld_bs", 32'h0100_0012, 0, 0, 0, 0, rd);
    chk("ld_bs_val", rd, 32'hFFFFFFAD);
    op2("ld_bu", 32'h0100_0012, 0, 0, 1, 0, rd);
    chk("ld_bu_val", rd, 32'h000000AD);
    op2("ld_hs", 32'h0100_0012, 0, 1, 0, 0, rd);
    chk("ld_hs_val", rd, 32'hFFFFDEAD);

    op2("bad_half", 32'h0100_0011, 1, 1, 0, 32'h1111_1111, rd);
    chk("bad_half_rd", rd, 0);
    op2("bad_word", 32'h0100_0012, 1, 2, 0, 32'h2222_2222, rd);
    op2("bad_size", 32'h0100_0010, 1, 3, 0, 32'h3333_3333, rd);
    op2("bad_low", 32'h00FF_FFFC, 0, 2, 0, 0, rd);
    chk("bad_low_rd", rd, 0);
    op2("bad_high", 32'h0100_1000, 0, 2, 0, 0, rd);
    op2("bad_wrap", 32'hFFFF_FFFC, 1, 2, 0, 32'h4444_4444, rd);
    op2("after_bad", 32'h0100_0010, 0, 2, 0, 0, rd);
    chk("after_bad_val", rd, 32'hDEAD7FEF);

    // Response stall with a competing request held on the request channel.
    v2.rsp_ready = 0; v2.req_valid = 1; v2.req_addr = 32'h0100_0010; v2.req_rw = 0;
    v2.req_size = 2; v2.req_unsign = 0;
    tick();
    v2.req_valid = 0;
    lat = 0;
    while (!v2.rsp_valid && lat < 20) begin tick(); lat++; end
    r0 = v2.rsp_rdata; e0 = v2.rsp_err;
    chk("stall_first", r0, 32'hDEAD7FEF);
    v2.req_valid = 1; v2.req_addr = 32'h0100_0012; v2.req_size = 0; v2.req_unsign = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", v2.rsp_valid, 1);
      chk("stall_rdata", v2.rsp_rdata, r0);
      chk("stall_err", v2.rsp_err, e0);
      chk("stall_req_ready", v2.req_ready, 0);
    end
    v2.rsp_ready = 1;
    tick();
    chk("hs_valid_drop", v2.rsp_valid, 0);
    chk("hs_idle_ready", v2.req_ready, 1);
    tick();
    chk("next_accepted", v2.req_ready, 0);
    v2.req_valid = 0;
    tick();
    chk("next_valid", v2.rsp_valid, 1);
    chk("next_rdata", v2.rsp_rdata, 32'h000000AD);
    tick();

    // Reset while a store sits in WAIT.
    op2("rz_init", 32'h0100_0020, 1, 2, 0, 32'h0, rd);
    v2.req_valid = 1; v2.req_addr = 32'h0100_0020; v2.req_rw = 1; v2.req_size = 2;
    v2.req_wdata = 32'h1234_5678;
    tick();
    v2.req_valid = 0;
    reset = 1;
    #1;
    chk("rz_req_ready", v2.req_ready, 1);
    chk("rz_rsp_valid", v2.rsp_valid, 0);
    chk("rz_rdata", v2.rsp_rdata, 0);
    chk("rz_err", v2.rsp_err, 0);
    tick();
    reset = 0;
    tick();
    op2("rz_load", 32'h0100_0020, 0, 2, 0, 0, rd);
    chk("rz_load_val", rd, 0);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 11))
        0:       a = 32'h0100_0000 - 32'($urandom_range(1, 16));
        1:       a = 32'h0100_1000 + 32'($urandom_range(0, 16));
        2:       a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: a = 32'h0100_0000 + 32'($urandom_range(0, 63));
      endcase
      op2("rnd", a, ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), 1'($urandom()), $urandom(), rd);
    end

    xact(v1, 32'h0100_0008, 1, 2, 0, 32'hCAFEF00D, rd, er, lat);
    chk("l1_st_lat", lat, 1);
    xact(v1, 32'h0100_0008, 0, 2, 0, 0, rd, er, lat);
    chk("l1_ld_lat", lat, 1);
    chk("l1_ld_val", rd, 32'hCAFEF00D);
    xact(v15, 32'h0100_0008, 1, 2, 0, 32'h0BADC0DE, rd, er, lat);
    chk("l15_st_lat", lat, 15);
    xact(v15, 32'h0100_0009, 0, 0, 1, 0, rd, er, lat);
    chk("l15_ld_lat", lat, 15);
    chk("l15_ld_val", rd, 32'h000000C0);
    chk("l15_ld_err", er, 0);

    thru(v1, 1, "thru_l1", 32'h0100_0008);
    thru(v2, 2, "thru_l2", 32'h0100_0010);
    thru(v15, 15, "thru_l15", 32'h0100_0008);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
